parc_pipe_stall_ctrl: RTL and testbench
=======================================

Name: parc_pipe_stall_ctrl

Overview:
- Central stall/sequencing controller for the 5-stage PARCv2 pipeline.
- Sequences the iterative muldiv unit occupying X and gates data-memory requests.
- Drives the one-entry dmem response queue in M and produces per-stage stall and bubble signals.
- Sits in the control unit beside hazard detection; all outputs feed the datapath stall/queue inputs directly.

Parameters:
- CNT_W, 16, width of saturating muldiv busy-cycle counter

Ports:
- clk  input  1  clock
- reset  input  1  reset
- inst_val_Xhl  input  1  valid instruction in X
- is_muldiv_Xhl  input  1  X instruction is mul/div/rem
- is_mem_Xhl  input  1  X instruction is load/store
- is_load_Mhl  input  1  valid load in M
- hazard_stall_Dhl  input  1  RAW/jump-reg hazard stall request from decode
- stall_ext_Whl  input  1  external writeback stall (coprocessor/test sink)
- muldivreq_rdy  input  1  muldiv accepts request
- muldivresp_val  input  1  muldiv result valid
- dmemreq_rdy  input  1  dmem accepts request
- dmemresp_val  input  1  dmem response valid
- muldivreq_val  output  1  issue muldiv request
- muldivresp_rdy  output  1  consume muldiv result
- dmemreq_val  output  1  issue dmem request
- dmemresp_queue_en_Mhl  output  1  capture response into queue register
- dmemresp_queue_val_Mhl  output  1  queue register holds M's load data
- stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl  output  1 each  stage stalls
- bubble_Xhl, bubble_Mhl, bubble_Whl  output  1 each  insert NOP into stage on next edge
- muldiv_busy  output  1  FSM not IDLE
- muldiv_cycles  output  CNT_W  saturating count of cycles with muldiv_busy=1

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: FSM=IDLE, queue_val=0, muldiv_cycles=0.
- Muldiv FSM states: IDLE, BUSY.
  - IDLE: muldivreq_val = inst_val_Xhl & is_muldiv_Xhl.
  - IDLE, accepted (val & rdy): go to BUSY.
  - IDLE, not accepted: hold val next cycle; no duplicate issue is possible.
  - BUSY: muldivreq_val=0.
  - BUSY, muldivresp_val=1 and stall_Mhl=0: muldivresp_rdy=1; X advances this edge; go to IDLE.
  - BUSY, muldivresp_val=1 and stall_Mhl=1: muldivresp_rdy=0; unit holds its result; stay BUSY.
- muldiv_stall_X = inst_val_Xhl & is_muldiv_Xhl & ~(BUSY & muldivresp_val).
- Dmem request:
  - dmemreq_val = inst_val_Xhl & is_mem_Xhl & ~stall_Mhl. This guarantees exactly one request per memory instruction.
  - mem_stall_X = inst_val_Xhl & is_mem_Xhl & (~dmemreq_rdy | stall_Mhl).
- Stall chain (combinational, no loops):
  - stall_Whl = stall_ext_Whl
  - stall_Mhl = stall_Whl | (is_load_Mhl & ~queue_val & ~dmemresp_val)
  - stall_Xhl = stall_Mhl | muldiv_stall_X | mem_stall_X
  - stall_Dhl = stall_Xhl | hazard_stall_Dhl
  - stall_Fhl = stall_Dhl
- Bubbles:
  - bubble_Xhl = stall_Dhl & ~stall_Xhl
  - bubble_Mhl = stall_Xhl & ~stall_Mhl
  - bubble_Whl = stall_Mhl & ~stall_Whl
- Response queue:
  - dmemresp_queue_en_Mhl = is_load_Mhl & dmemresp_val & stall_Mhl & ~queue_val.
  - queue_val is set on en and cleared on any edge where stall_Mhl=0.
  - Set and clear never coincide, because en requires stall_Mhl=1.
  - dmemresp_queue_val_Mhl = queue_val.
  - A response arriving while queue_val=1 is a protocol violation. Flag it with an assertion in simulation only.
- Counter: muldiv_cycles increments each cycle the FSM is BUSY and saturates at 2^CNT_W-1.
- Reset mid-operation: FSM returns to IDLE and queue_val clears. The muldiv unit is reset on the same edge; no stale response is consumed.

Decomposition:
- Shared control package holds the FSM state encodings (IDLE=1'b0, BUSY=1'b1) and the stall-source bit positions.
- One sub-module: parc_muldiv_seq, holding the FSM, the req/resp handshake and the counter.
- The stall chain, bubbles and queue logic stay in the top module.

Test Plan:
- Mul in X, muldivreq_rdy=1, response after 33 cycles, no other stalls -> req pulse 1 cycle; stall_Xhl=1 for 33 cycles; rdy=1 on response cycle; muldiv_cycles=33.
- Div in X, muldivreq_rdy=0 for 3 cycles -> muldivreq_val held 4 cycles; FSM enters BUSY only after acceptance; exactly one request.
- Load in M, dmemresp_val delayed 2 cycles -> stall_Mhl=1 for 2 cycles; bubble_Whl=1 for those 2 cycles; stall_Xhl and stall_Dhl=1.
- Load in M, response arrives while stall_ext_Whl=1 for 3 cycles -> queue_en 1 cycle; queue_val=1 until stall_ext drops; then clears; no re-wait.
- Muldiv response valid while stall_ext_Whl=1 -> muldivresp_rdy=0; FSM stays BUSY; result consumed on first cycle stall_ext=0.
- Reset asserted in BUSY with queue_val=1 -> next cycle: FSM IDLE, queue_val=0, muldiv_cycles=0, all stalls reflect inputs only.

Source files
------------

// File: rtl/parc_pipe_stall_ctrl_pkg.sv
// rtl/parc_pipe_stall_ctrl_pkg.sv - shared encodings for the PARCv2 pipeline stall controller
package parc_pipe_stall_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_e;

    // Bit positions of the individual stall sources in the controller's source vector.
    localparam int STALL_SRC_W        = 5;
    localparam int STALL_SRC_EXT_W    = 0;
    localparam int STALL_SRC_LOAD_M   = 1;
    localparam int STALL_SRC_MULDIV_X = 2;
    localparam int STALL_SRC_MEM_X    = 3;
    localparam int STALL_SRC_HAZARD_D = 4;

endpackage

// File: rtl/parc_pipe_stall_ctrl_muldiv_seq.sv
// rtl/parc_pipe_stall_ctrl_muldiv_seq.sv - muldiv request/response sequencer with busy-cycle counter
module parc_muldiv_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_val_Xhl,
    input  logic             is_muldiv_Xhl,
    input  logic             stall_Mhl,
    input  logic             muldivreq_rdy,
    input  logic             muldivresp_val,
    output logic             muldivreq_val,
    output logic             muldivresp_rdy,
    output logic             muldiv_stall_X,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] muldiv_cycles
);
    import parc_pipe_stall_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    // State and counter registers; the muldiv unit resets on the same edge, so no stale response survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
        end
    end

    // Handshake and next state: issue once from IDLE, hold until accepted, retire only when M can take it.
    always_comb begin
        state_d        = state_q;
        muldivreq_val  = 1'b0;
        muldivresp_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                muldivreq_val = inst_val_Xhl & is_muldiv_Xhl;
                if (muldivreq_val & muldivreq_rdy) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (muldivresp_val & ~stall_Mhl) begin
                    muldivresp_rdy = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of cycles spent waiting on the muldiv unit.
    always_comb begin
        cycles_d = cycles_q;
        if ((state_q == BUSY) && (cycles_q != CNT_MAX)) begin
            cycles_d = cycles_q + CNT_ONE;
        end
    end

    assign muldiv_busy    = (state_q == BUSY);
    assign muldiv_stall_X = inst_val_Xhl & is_muldiv_Xhl & ~(muldiv_busy & muldivresp_val);
    assign muldiv_cycles  = cycles_q;

endmodule

// File: rtl/parc_pipe_stall_ctrl.sv
// rtl/parc_pipe_stall_ctrl.sv - PARCv2 stall chain, bubbles, dmem gating and response queue
module parc_pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_val_Xhl,
    input  logic             is_muldiv_Xhl,
    input  logic             is_mem_Xhl,
    input  logic             is_load_Mhl,
    input  logic             hazard_stall_Dhl,
    input  logic             stall_ext_Whl,
    input  logic             muldivreq_rdy,
    input  logic             muldivresp_val,
    input  logic             dmemreq_rdy,
    input  logic             dmemresp_val,
    output logic             muldivreq_val,
    output logic             muldivresp_rdy,
    output logic             dmemreq_val,
    output logic             dmemresp_queue_en_Mhl,
    output logic             dmemresp_queue_val_Mhl,
    output logic             stall_Fhl,
    output logic             stall_Dhl,
    output logic             stall_Xhl,
    output logic             stall_Mhl,
    output logic             stall_Whl,
    output logic             bubble_Xhl,
    output logic             bubble_Mhl,
    output logic             bubble_Whl,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] muldiv_cycles
);
    import parc_pipe_stall_ctrl_pkg::*;

    logic                   queue_val_q, queue_val_d;
    logic                   muldiv_stall_X;
    logic [STALL_SRC_W-1:0] stall_src;

    parc_muldiv_seq #(
        .CNT_W (CNT_W)
    ) u_muldiv_seq (
        .clk            (clk),
        .reset          (reset),
        .inst_val_Xhl   (inst_val_Xhl),
        .is_muldiv_Xhl  (is_muldiv_Xhl),
        .stall_Mhl      (stall_Mhl),
        .muldivreq_rdy  (muldivreq_rdy),
        .muldivresp_val (muldivresp_val),
        .muldivreq_val  (muldivreq_val),
        .muldivresp_rdy (muldivresp_rdy),
        .muldiv_stall_X (muldiv_stall_X),
        .muldiv_busy    (muldiv_busy),
        .muldiv_cycles  (muldiv_cycles)
    );

    // Raw stall sources. The memory source here is only the "dmem not ready" part;
    // its "M is stalled" part is already covered by stall_Mhl in the chain below.
    always_comb begin
        stall_src                     = '0;
        stall_src[STALL_SRC_EXT_W]    = stall_ext_Whl;
        stall_src[STALL_SRC_LOAD_M]   = is_load_Mhl & ~queue_val_q & ~dmemresp_val;
        stall_src[STALL_SRC_MULDIV_X] = muldiv_stall_X;
        stall_src[STALL_SRC_MEM_X]    = inst_val_Xhl & is_mem_Xhl & ~dmemreq_rdy;
        stall_src[STALL_SRC_HAZARD_D] = hazard_stall_Dhl;
    end

    // Stalls propagate from W back to F; a bubble enters a stage whose upstream stalls while it moves.
    always_comb begin
        stall_Whl  = stall_src[STALL_SRC_EXT_W];
        stall_Mhl  = stall_Whl | stall_src[STALL_SRC_LOAD_M];
        stall_Xhl  = stall_Mhl | stall_src[STALL_SRC_MULDIV_X] | stall_src[STALL_SRC_MEM_X];
        stall_Dhl  = stall_Xhl | stall_src[STALL_SRC_HAZARD_D];
        stall_Fhl  = stall_Dhl;
        bubble_Xhl = stall_Dhl & ~stall_Xhl;
        bubble_Mhl = stall_Xhl & ~stall_Mhl;
        bubble_Whl = stall_Mhl & ~stall_Whl;
    end

    // Only issue the dmem request on the cycle X actually moves, so each memory op issues once.
    assign dmemreq_val = inst_val_Xhl & is_mem_Xhl & ~stall_Mhl;

    // Park a load response that arrives while M is held; the entry frees as soon as M advances.
    always_comb begin
        dmemresp_queue_en_Mhl = is_load_Mhl & dmemresp_val & stall_Mhl & ~queue_val_q;
        queue_val_d           = queue_val_q;
        if (dmemresp_queue_en_Mhl) begin
            queue_val_d = 1'b1;
        end else if (~stall_Mhl) begin
            queue_val_d = 1'b0;
        end
    end

    // Queue-valid register.
    always_ff @(posedge clk) begin
        if (reset) begin
            queue_val_q <= 1'b0;
        end else begin
            queue_val_q <= queue_val_d;
        end
    end

    assign dmemresp_queue_val_Mhl = queue_val_q;

    a_no_resp_overrun: assert property (@(posedge clk) disable iff (reset)
        !(queue_val_q && dmemresp_val));

endmodule

// File: tb/tb_parc_pipe_stall_ctrl.sv
// tb/tb_parc_pipe_stall_ctrl.sv - self-checking bench for parc_pipe_stall_ctrl
module tb_parc_pipe_stall_ctrl;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, inst_val_Xhl, is_muldiv_Xhl, is_mem_Xhl, is_load_Mhl;
    logic hazard_stall_Dhl, stall_ext_Whl, muldivreq_rdy, muldivresp_val;
    logic dmemreq_rdy, dmemresp_val;
    logic muldivreq_val, muldivresp_rdy, dmemreq_val;
    logic dmemresp_queue_en_Mhl, dmemresp_queue_val_Mhl;
    logic stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
    logic bubble_Xhl, bubble_Mhl, bubble_Whl, muldiv_busy;
    logic [CNT_W-1:0] muldiv_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parc_pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .inst_val_Xhl           (inst_val_Xhl),
        .is_muldiv_Xhl          (is_muldiv_Xhl),
        .is_mem_Xhl             (is_mem_Xhl),
        .is_load_Mhl            (is_load_Mhl),
        .hazard_stall_Dhl       (hazard_stall_Dhl),
        .stall_ext_Whl          (stall_ext_Whl),
        .muldivreq_rdy          (muldivreq_rdy),
        .muldivresp_val         (muldivresp_val),
        .dmemreq_rdy            (dmemreq_rdy),
        .dmemresp_val           (dmemresp_val),
        .muldivreq_val          (muldivreq_val),
        .muldivresp_rdy         (muldivresp_rdy),
        .dmemreq_val            (dmemreq_val),
        .dmemresp_queue_en_Mhl  (dmemresp_queue_en_Mhl),
        .dmemresp_queue_val_Mhl (dmemresp_queue_val_Mhl),
        .stall_Fhl              (stall_Fhl),
        .stall_Dhl              (stall_Dhl),
        .stall_Xhl              (stall_Xhl),
        .stall_Mhl              (stall_Mhl),
        .stall_Whl              (stall_Whl),
        .bubble_Xhl             (bubble_Xhl),
        .bubble_Mhl             (bubble_Mhl),
        .bubble_Whl             (bubble_Whl),
        .muldiv_busy            (muldiv_busy),
        .muldiv_cycles          (muldiv_cycles)
    );

    logic [13:0] got_v;
    assign got_v = {muldivreq_val, muldivresp_rdy, dmemreq_val, dmemresp_queue_en_Mhl,
                    dmemresp_queue_val_Mhl, stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl,
                    stall_Whl, bubble_Xhl, bubble_Mhl, bubble_Whl, muldiv_busy};

    // Reference model: "a muldiv op is outstanding", "a load response is parked", busy-cycle tally.
    bit          m_busy, m_q, n_busy, n_q;
    int          m_cnt, n_cnt;
    logic [13:0] exp_v;

    function automatic void model_eval();
        bit sw, sm, sx, sd, md_st, mem_st, mreq, mrdy, dreq, qen;
        sw     = stall_ext_Whl;
        sm     = sw || (is_load_Mhl && !m_q && !dmemresp_val);
        md_st  = inst_val_Xhl && is_muldiv_Xhl && !(m_busy && muldivresp_val);
        mem_st = inst_val_Xhl && is_mem_Xhl && (!dmemreq_rdy || sm);
        sx     = sm || md_st || mem_st;
        sd     = sx || hazard_stall_Dhl;
        mreq   = !m_busy && inst_val_Xhl && is_muldiv_Xhl;
        mrdy   = m_busy && muldivresp_val && !sm;
        dreq   = inst_val_Xhl && is_mem_Xhl && !sm;
        qen    = is_load_Mhl && dmemresp_val && sm && !m_q;
        exp_v  = {mreq, mrdy, dreq, qen, m_q, sd, sd, sx, sm, sw,
                  sd && !sx, sx && !sm, sm && !sw, m_busy};
        if (reset) begin
            n_busy = 0; n_q = 0; n_cnt = 0;
        end else begin
            n_cnt  = m_busy ? ((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1) : m_cnt;
            n_busy = m_busy ? !mrdy : (mreq && muldivreq_rdy);
            n_q    = qen ? 1'b1 : (sm ? m_q : 1'b0);
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        m_busy = n_busy; m_q = n_q; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_val_Xhl = 0; is_muldiv_Xhl = 0; is_mem_Xhl = 0; is_load_Mhl = 0;
        hazard_stall_Dhl = 0; stall_ext_Whl = 0; muldivreq_rdy = 1; muldivresp_val = 0;
        dmemreq_rdy = 1; dmemresp_val = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0; #1; model_eval();
        checks++; if (muldiv_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", muldiv_busy); end
        checks++; if (dmemresp_queue_val_Mhl !== 1'b0) begin failures++; $display("FAIL reset_qval got=%b exp=0", dmemresp_queue_val_Mhl); end
        checks++; if (muldiv_cycles !== '0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", muldiv_cycles); end
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL reset_vec got=%b exp=%b", got_v, exp_v); end
    endtask

    task automatic test_mul_basic();
        int st = 0, rq = 0;
        logic rdy_at_resp = 0;
        inst_val_Xhl = 1; is_muldiv_Xhl = 1; muldivreq_rdy = 1;
        for (int c = 0; c <= 33; c++) begin
            muldivresp_val = (c == 33);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL mul_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            if (stall_Xhl) st++;
            if (muldivreq_val) rq++;
            if (c == 33) rdy_at_resp = muldivresp_rdy;
            tick();
        end
        idle_inputs(); #1;
        checks++; if (st != 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", st); end
        checks++; if (rq != 1) begin failures++; $display("FAIL mul_req_pulses got=%0d exp=1", rq); end
        checks++; if (rdy_at_resp !== 1'b1) begin failures++; $display("FAIL mul_resp_rdy got=%b exp=1", rdy_at_resp); end
        checks++; if (muldiv_busy !== 1'b0) begin failures++; $display("FAIL mul_idle got=%b exp=0", muldiv_busy); end
        checks++; if (muldiv_cycles !== 6'd33) begin failures++; $display("FAIL mul_cycles got=%0d exp=33", muldiv_cycles); end
    endtask

    task automatic test_div_req_wait();
        int rq = 0;
        logic busy3 = 1, busy4 = 0;
        inst_val_Xhl = 1; is_muldiv_Xhl = 1;
        for (int c = 0; c <= 5; c++) begin
            muldivreq_rdy  = (c >= 3);
            muldivresp_val = (c == 5);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL div_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            if (muldivreq_val) rq++;
            if (c == 3) busy3 = muldiv_busy;
            if (c == 4) busy4 = muldiv_busy;
            tick();
        end
        idle_inputs(); #1;
        checks++; if (rq != 4) begin failures++; $display("FAIL div_req_cycles got=%0d exp=4", rq); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL div_busy_before_accept got=%b exp=0", busy3); end
        checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL div_busy_after_accept got=%b exp=1", busy4); end
    endtask

    task automatic test_load_delay();
        int sm = 0, bw = 0, sxd = 0;
        is_load_Mhl = 1;
        for (int c = 0; c <= 2; c++) begin
            dmemresp_val = (c == 2);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL ld_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            if (stall_Mhl) sm++;
            if (bubble_Whl) bw++;
            if (stall_Xhl && stall_Dhl) sxd++;
            tick();
        end
        idle_inputs();
        checks++; if (sm != 2) begin failures++; $display("FAIL ld_stallM_cycles got=%0d exp=2", sm); end
        checks++; if (bw != 2) begin failures++; $display("FAIL ld_bubbleW_cycles got=%0d exp=2", bw); end
        checks++; if (sxd != 2) begin failures++; $display("FAIL ld_stallXD_cycles got=%0d exp=2", sxd); end
    endtask

    task automatic test_load_queue();
        int qen = 0, qv = 0;
        logic sm3 = 1;
        is_load_Mhl = 1;
        for (int c = 0; c <= 3; c++) begin
            stall_ext_Whl = (c < 3);
            dmemresp_val  = (c == 0);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL q_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            if (dmemresp_queue_en_Mhl) qen++;
            if (dmemresp_queue_val_Mhl) qv++;
            if (c == 3) sm3 = stall_Mhl;
            tick();
        end
        idle_inputs(); #1;
        checks++; if (qen != 1) begin failures++; $display("FAIL q_en_cycles got=%0d exp=1", qen); end
        checks++; if (qv != 3) begin failures++; $display("FAIL q_val_cycles got=%0d exp=3", qv); end
        checks++; if (sm3 !== 1'b0) begin failures++; $display("FAIL q_no_rewait got=%b exp=0", sm3); end
        checks++; if (dmemresp_queue_val_Mhl !== 1'b0) begin failures++; $display("FAIL q_cleared got=%b exp=0", dmemresp_queue_val_Mhl); end
    endtask

    task automatic test_muldiv_resp_stall();
        logic [3:0] rdy_seq = '0;
        logic busy3 = 0;
        inst_val_Xhl = 1; is_muldiv_Xhl = 1;
        for (int c = 0; c <= 3; c++) begin
            muldivresp_val = (c >= 1);
            stall_ext_Whl  = (c == 1 || c == 2);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL mdst_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            rdy_seq[c] = muldivresp_rdy;
            if (c == 3) busy3 = muldiv_busy;
            tick();
        end
        idle_inputs(); #1;
        checks++; if (rdy_seq !== 4'b1000) begin failures++; $display("FAIL mdst_rdy_seq got=%b exp=1000", rdy_seq); end
        checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL mdst_held_busy got=%b exp=1", busy3); end
        checks++; if (muldiv_busy !== 1'b0) begin failures++; $display("FAIL mdst_consumed got=%b exp=0", muldiv_busy); end
    endtask

    task automatic test_saturation();
        inst_val_Xhl = 1; is_muldiv_Xhl = 1;
        for (int c = 0; c <= 71; c++) begin
            muldivresp_val = (c == 71);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL sat_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            tick();
        end
        idle_inputs(); #1;
        checks++; if (muldiv_cycles !== 6'd63) begin failures++; $display("FAIL sat_cycles got=%0d exp=63", muldiv_cycles); end
        checks++; if (muldiv_cycles !== CNT_W'(m_cnt)) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", muldiv_cycles, m_cnt); end
    endtask

    task automatic test_reset_mid();
        inst_val_Xhl = 1; is_muldiv_Xhl = 1;
        tick();
        inst_val_Xhl = 0; is_muldiv_Xhl = 0;
        is_load_Mhl = 1; stall_ext_Whl = 1; dmemresp_val = 1;
        tick();
        dmemresp_val = 0; #1;
        checks++; if ({muldiv_busy, dmemresp_queue_val_Mhl} !== 2'b11) begin failures++; $display("FAIL rmid_pre got=%b exp=11", {muldiv_busy, dmemresp_queue_val_Mhl}); end
        reset = 1;
        tick();
        reset = 0; stall_ext_Whl = 0; #1; model_eval();
        checks++; if (muldiv_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", muldiv_busy); end
        checks++; if (dmemresp_queue_val_Mhl !== 1'b0) begin failures++; $display("FAIL rmid_qval got=%b exp=0", dmemresp_queue_val_Mhl); end
        checks++; if (muldiv_cycles !== '0) begin failures++; $display("FAIL rmid_cycles got=%0d exp=0", muldiv_cycles); end
        checks++; if ({stall_Mhl, stall_Whl, bubble_Whl} !== 3'b101) begin failures++; $display("FAIL rmid_stalls got=%b exp=101", {stall_Mhl, stall_Whl, bubble_Whl}); end
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rmid_vec got=%b exp=%b", got_v, exp_v); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset            = ($urandom_range(0, 49) == 0);
            inst_val_Xhl     = $urandom_range(0, 3) != 0;
            is_muldiv_Xhl    = $urandom_range(0, 2) == 0;
            is_mem_Xhl       = $urandom_range(0, 2) == 0;
            is_load_Mhl      = $urandom_range(0, 1);
            hazard_stall_Dhl = $urandom_range(0, 4) == 0;
            stall_ext_Whl    = $urandom_range(0, 3) == 0;
            muldivreq_rdy    = $urandom_range(0, 1);
            muldivresp_val   = m_busy && ($urandom_range(0, 3) == 0);
            dmemreq_rdy      = $urandom_range(0, 3) != 0;
            dmemresp_val     = !m_q && ($urandom_range(0, 1) == 0);
            #1; model_eval();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rnd_vec cyc=%0d got=%b exp=%b", c, got_v, exp_v); end
            checks++; if (muldiv_cycles !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rnd_cycles cyc=%0d got=%0d exp=%0d", c, muldiv_cycles, m_cnt); end
            tick();
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        m_busy = 0; m_q = 0; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_mul_basic();
        test_div_req_wait();
        test_load_delay();
        test_load_queue();
        test_muldiv_resp_stall();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
